// File: rtl/alu_simd_accum_ctrl.sv
// Sequencer for the 45-bit SIMD ALU slice. It streams N operand pairs into
// the ALU, feeds the accumulator back on Y, registers each ALU sum, and
// presents the final sum with sticky per-lane carry flags on a
// valid/ready output port.
module alu_simd_accum_ctrl #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 45
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              cfg_cin,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0] in_x,
    output logic [1:0]        alu_use_simd,
    output logic [DATA_W-1:0] alu_w,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_cin,
    output logic [7:0]        alu_carry_in,
    input  logic [DATA_W-1:0] alu_s,
    input  logic [7:0]        alu_carry_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_carry
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCUM  = 2'b01,
        OUTPUT = 2'b10
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt;
    logic               cin_q;
    logic [DATA_W-1:0]  acc;
    logic [7:0]         carry_q;
    logic               busy_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    // Mode 11 is not a distinct ALU mode; it behaves as sum_4x4.
    logic [1:0] mode_mapped;
    assign mode_mapped = (cfg_mode == 2'b11) ? 2'b10 : cfg_mode;

    // Compare against len_q - 1 rather than cnt + 1 so that a full-scale
    // length never needs cnt to wrap before the last term is recognised.
    logic last_term;
    assign last_term = (cnt == (len_q - CNT_W'(1)));

    logic accept;
    assign accept = in_valid && in_ready_reg;

    // Transaction FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mode_q        <= 2'b00;
            len_q         <= '0;
            cnt           <= '0;
            cin_q         <= 1'b0;
            acc           <= '0;
            carry_q       <= '0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode_mapped;
                        len_q    <= cfg_len;
                        cin_q    <= cfg_cin;
                        cnt      <= '0;
                        acc      <= '0;
                        carry_q  <= '0;
                        busy_reg <= 1'b1;
                        if (cfg_len != '0) begin
                            state        <= ACCUM;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state         <= OUTPUT;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc     <= alu_s;
                        carry_q <= carry_q | alu_carry_out;
                        cnt     <= cnt + CNT_W'(1);
                        if (last_term) begin
                            state         <= OUTPUT;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    // acc and carry_q are left alone so the last result
                    // remains observable until the next start.
                    if (out_ready) begin
                        state         <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // ALU drive: operands pass straight through while accepting terms; the
    // ALU is combinational so its sum is captured on the handshake edge.
    always_comb begin
        alu_use_simd = busy_reg ? mode_q : 2'b00;
        alu_w        = in_ready_reg ? in_w : '0;
        alu_x        = in_ready_reg ? in_x : '0;
        alu_y        = acc;
        alu_cin      = (in_ready_reg && (cnt == '0)) ? cin_q : 1'b0;
        alu_carry_in = 8'h00;
    end

    // Status and result ports.
    always_comb begin
        busy      = busy_reg;
        in_ready  = in_ready_reg;
        out_valid = out_valid_reg;
        out_data  = acc;
        out_carry = carry_q;
    end

endmodule

// File: tb/tb_alu_simd_accum_ctrl.sv
// Bench for alu_simd_accum_ctrl: a behavioural ALU slice model drives alu_s
// from the controller's ALU outputs, and a per-transaction reference sum is
// derived from the configured mode, carry-in and terms.
module tb_alu_simd_accum_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_len;
    logic        cfg_cin;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [44:0] in_w;
    logic [44:0] in_x;
    logic [1:0]  alu_use_simd;
    logic [44:0] alu_w;
    logic [44:0] alu_x;
    logic [44:0] alu_y;
    logic        alu_cin;
    logic [7:0]  alu_carry_in;
    logic [44:0] alu_s;
    logic [7:0]  alu_carry_out;
    logic        out_valid;
    logic        out_ready;
    logic [44:0] out_data;
    logic [7:0]  out_carry;

    int n_vec = 0;
    int n_err = 0;
    string cur_name = "init";

    logic [44:0] tw [256];
    logic [44:0] tx [256];
    int          tg [256];

    alu_simd_accum_ctrl #(.CNT_W(8), .DATA_W(45)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
        .cfg_len(cfg_len), .cfg_cin(cfg_cin), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_x(in_x),
        .alu_use_simd(alu_use_simd), .alu_w(alu_w), .alu_x(alu_x),
        .alu_y(alu_y), .alu_cin(alu_cin), .alu_carry_in(alu_carry_in),
        .alu_s(alu_s), .alu_carry_out(alu_carry_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    function automatic int lane_w(input int i);
        case (i)
            0: return 17;
            1: return 10;
            2: return 8;
            default: return 10;
        endcase
    endfunction

    // ALU slice model: mode 00 is one 45-bit adder (carry-out on bit 3);
    // sum modes split into isolated 17/10/8/10 lanes, CIN enters lane 0,
    // carry-out bit i flags overflow of lane i.
    function automatic logic [52:0] alu_model(input logic [1:0] m,
            input logic [44:0] w, input logic [44:0] x,
            input logic [44:0] y, input logic c);
        logic [63:0] sum;
        logic [63:0] mask;
        logic [44:0] s;
        logic [7:0]  co;
        int off;
        s = '0;
        co = '0;
        if (m == 2'b00) begin
            sum = {19'b0, w} + {19'b0, x} + {19'b0, y} + {63'b0, c};
            s = sum[44:0];
            co[3] = |sum[63:45];
        end else begin
            off = 0;
            for (int i = 0; i < 4; i++) begin
                mask = (64'd1 << lane_w(i)) - 64'd1;
                sum = (({19'b0, w} >> off) & mask) + (({19'b0, x} >> off) & mask)
                    + (({19'b0, y} >> off) & mask) + ((i == 0) ? {63'b0, c} : 64'd0);
                s = s | 45'((sum & mask) << off);
                co[i] = ((sum >> lane_w(i)) != 64'd0);
                off += lane_w(i);
            end
        end
        return {co, s};
    endfunction

    logic [52:0] alu_r;
    always_comb begin
        alu_r = alu_model(alu_use_simd, alu_w, alu_x, alu_y, alu_cin);
        alu_s = alu_r[44:0];
        alu_carry_out = alu_r[52:45];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%h expected=%h", cur_name, tag, obs, exp);
        end
    endtask

    task automatic fill_rand(input int len, input int maxgap);
        for (int k = 0; k < len; k++) begin
            tw[k] = 45'({$urandom, $urandom});
            tx[k] = 45'({$urandom, $urandom});
            tg[k] = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
        end
    endtask

    // Runs one transaction starting at posedge+1 with the DUT idle.
    task automatic run_txn(input logic [1:0] mode, input logic [7:0] len, input logic cin,
                           input int hold, input bit start_gap, input bit start_hs);
        logic [1:0]  eff;
        logic [44:0] acc_m;
        logic [7:0]  car_m;
        logic [52:0] r;
        logic        c_t;
        eff   = (mode == 2'b11) ? 2'b10 : mode;
        acc_m = '0;
        car_m = '0;
        start = 1'b1; cfg_mode = mode; cfg_len = len; cfg_cin = cin;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_mode = 2'($urandom); cfg_len = 8'($urandom); cfg_cin = 1'($urandom);
        chk("busy_after_start", busy, 1);
        chk("use_simd_after_start", alu_use_simd, eff);
        chk("in_ready_after_start", in_ready, (len != 0));
        for (int k = 0; k < len; k++) begin
            for (int g = 0; g < tg[k]; g++) begin
                in_valid = 1'b0;
                start = start_gap;
                in_w = 45'({$urandom, $urandom});
                #1;
                chk("in_ready_gap", in_ready, 1);
                @(posedge clk); #1;
            end
            start = 1'b0;
            in_valid = 1'b1; in_w = tw[k]; in_x = tx[k];
            c_t = (k == 0) ? cin : 1'b0;
            #1;
            chk("in_ready_term", in_ready, 1);
            chk("alu_cin", alu_cin, c_t);
            chk("alu_use_simd", alu_use_simd, eff);
            chk("alu_y", alu_y, acc_m);
            r = alu_model(eff, tw[k], tx[k], acc_m, c_t);
            acc_m = r[44:0];
            car_m = car_m | r[52:45];
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, acc_m);
        chk("out_carry", out_carry, car_m);
        chk("in_ready_output", in_ready, 0);
        chk("use_simd_output", alu_use_simd, eff);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, acc_m);
            chk("hold_carry", out_carry, car_m);
        end
        $display("txn %s mode=%0d len=%0d cin=%0d out_data=%h out_carry=%h",
                 cur_name, mode, len, cin, out_data, out_carry);
        out_ready = 1'b1;
        start = start_hs;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_after_hs", out_valid, 0);
        chk("busy_after_hs", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_mode = 2'b00; cfg_len = 8'd0; cfg_cin = 1'b0;
        in_valid = 1'b0; in_w = '0; in_x = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cur_name = "reset";
        chk("busy", busy, 0);
        chk("in_ready", in_ready, 0);
        chk("out_valid", out_valid, 0);
        chk("out_data", out_data, 0);
        chk("out_carry", out_carry, 0);
        chk("use_simd", alu_use_simd, 0);
        chk("alu_cin", alu_cin, 0);
        chk("alu_carry_in", alu_carry_in, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        cur_name = "m00_len3";
        tw[0] = 45'd1; tx[0] = 45'd2; tw[1] = 45'd3; tx[1] = 45'd4;
        tw[2] = 45'd5; tx[2] = 45'd6;
        tg[0] = 0; tg[1] = 0; tg[2] = 0;
        run_txn(2'b00, 8'd3, 1'b0, 1, 1'b0, 1'b0);
        chk("sum21", out_data, 45'd21);

        cur_name = "m00_cin";
        tw[0] = 45'h1FFFF; tx[0] = 45'd0; tg[0] = 0;
        run_txn(2'b00, 8'd1, 1'b1, 0, 1'b0, 1'b0);
        chk("lane_cross", out_data, 45'h20000);
        chk("lane_cross_carry", out_carry, 8'h00);

        cur_name = "m01_wrap";
        tw[0] = 45'h1FFFF; tx[0] = 45'd0; tw[1] = 45'h1FFFF; tx[1] = 45'd0;
        tg[0] = 0; tg[1] = 0;
        run_txn(2'b01, 8'd2, 1'b0, 0, 1'b0, 1'b0);
        chk("lane0_wrap", out_data, 45'h1FFFE);
        chk("lane0_carry", out_carry, 8'h01);

        cur_name = "m11_len0";
        run_txn(2'b11, 8'd0, 1'b0, 5, 1'b0, 1'b0);
        chk("len0_data", out_data, 45'd0);

        cur_name = "toggle_start";
        fill_rand(2, 0);
        tg[1] = 2;
        run_txn(2'b10, 8'd2, 1'b1, 1, 1'b1, 1'b0);

        // Reset part-way through a four-term transaction.
        cur_name = "reset_mid";
        start = 1'b1; cfg_mode = 2'b01; cfg_len = 8'd4; cfg_cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_w = 45'h0_1234_5678; in_x = 45'h0_0F0F_0F0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("still_accum", in_ready, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("busy_async", busy, 0);
        chk("in_ready_async", in_ready, 0);
        chk("out_valid_async", out_valid, 0);
        chk("out_data_async", out_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cur_name = "after_reset";
        tw[0] = 45'd100; tx[0] = 45'd23; tg[0] = 0;
        run_txn(2'b00, 8'd1, 1'b0, 0, 1'b0, 1'b1);
        chk("single_term", out_data, 45'd123);
        // start was held through the OUTPUT->IDLE edge and must not be taken.
        cur_name = "start_at_hs";
        chk("idle_after_hs", busy, 0);

        for (int t = 0; t < 20; t++) begin
            int len;
            cur_name = $sformatf("rand%0d", t);
            len = int'($urandom_range(8, 1));
            fill_rand(len, 2);
            run_txn(2'($urandom), 8'(len), 1'($urandom), int'($urandom_range(3, 0)),
                    1'($urandom), 1'($urandom));
        end

        cur_name = "len255";
        fill_rand(255, 0);
        run_txn(2'b01, 8'd255, 1'b1, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_simd_accum_ctrl.md
Name: alu_simd_accum_ctrl

Overview:
- Sequencer for the 45-bit SIMD ALU slice (four lanes: 17/10/8/10 bits, modes 27x18, sum_9x9, sum_4x4).
- Accepts a configured transaction of N operand pairs over a valid/ready stream and drives the ALU with the accumulator fed back on Y. It registers S each accepted term and presents the final sum on an output valid/ready port.
- Holds USE_SIMD stable for the whole transaction and collects per-lane carry-outs as sticky overflow flags.

Parameters:
- CNT_W, 8, width of the term counter and cfg_len.
- DATA_W, 45, ALU datapath width (fixed by the ALU slice; not for override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  transaction request; sampled only in IDLE.
- cfg_mode  in  2  SIMD mode: 00 = 27x18, 01 = sum_9x9, 10 = sum_4x4, 11 = treated as 10.
- cfg_len  in  CNT_W  number of terms to accumulate.
- cfg_cin  in  1  carry-in applied on the first term only.
- busy  out  1  high whenever state is not IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller accepts an operand pair.
- in_w  in  DATA_W  operand routed to ALU W.
- in_x  in  DATA_W  operand routed to ALU X.
- alu_use_simd  out  2  to ALU USE_SIMD.
- alu_w  out  DATA_W  to ALU W.
- alu_x  out  DATA_W  to ALU X.
- alu_y  out  DATA_W  to ALU Y (accumulator).
- alu_cin  out  1  to ALU CIN.
- alu_carry_in  out  8  to ALU result_SIMD_carry_in; tied 0.
- alu_s  in  DATA_W  from ALU S.
- alu_carry_out  in  8  from ALU result_SIMD_carry_out.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_data  out  DATA_W  accumulated result.
- out_carry  out  8  sticky OR of alu_carry_out over the transaction.

Behaviour:
- States: IDLE, ACCUM, OUTPUT. Reset forces IDLE.
- Reset clears mode_q, len_q, cnt, acc and carry_q to 0. Outputs under reset: busy 0, in_ready 0, out_valid 0, out_data 0, out_carry 0, alu_use_simd 00, alu_cin 0.
- IDLE:
  - in_ready = 0.
  - alu_use_simd = 00, alu_w/alu_x = 0, alu_y = acc.
  - On start = 1: latch mode (11 mapped to 10), len, cin; clear cnt, acc and carry_q.
  - Next state is ACCUM if cfg_len != 0; otherwise OUTPUT with acc = 0 and carry_q = 0.
- ACCUM:
  - in_ready = 1.
  - alu_use_simd = mode_q; alu_w = in_w, alu_x = in_x, alu_y = acc.
  - alu_cin = cin_q when cnt == 0, else 0.
  - The ALU is combinational; the controller adds no ALU pipeline stage.
  - On in_valid & in_ready: acc <= alu_s; carry_q <= carry_q | alu_carry_out; cnt <= cnt + 1.
  - If cnt == len_q - 1 at that handshake, go to OUTPUT.
  - in_valid low: hold all state; alu_cin keeps its value.
- OUTPUT:
  - out_valid = 1, out_data = acc, out_carry = carry_q; in_ready = 0.
  - alu_use_simd holds mode_q.
  - On out_ready = 1: go to IDLE. acc and carry_q keep their value until the next start.
  - out_data/out_carry stay stable while out_valid is high and out_ready is low.
- Latency:
  - First in_ready asserts the cycle after start.
  - Result is available 1 cycle after the last accepted term.
  - Minimum transaction is 1 (start) + N (terms) + 1 (output) cycles.
- Boundary conditions:
  - start while busy: ignored; cfg_* changes mid-transaction have no effect.
  - start in the same cycle as the OUTPUT→IDLE transition: not sampled; it is taken the following cycle.
  - cfg_len = 2^CNT_W - 1: cnt must not wrap before the compare.
  - Lane sums wrap modulo lane width. In sum modes, inter-lane carries are isolated by the ALU; only carry_q records overflow.
  - Asynchronous reset mid-ACCUM or mid-OUTPUT: immediate IDLE; partial result discarded; out_valid drops without handshake.
- Arithmetic: acc_next = W + X + acc + CIN under the latched mode's carry chain; no saturation.

Test Plan:
- Mode 00, len 3, cin 0; (W,X) = (1,2), (3,4), (5,6) -> out_data = 21, out_carry = 0, out_valid 1 cycle after 3rd handshake.
- Mode 00, len 1, cin 1; W = 0x1FFFF, X = 0 -> out_data = 0x20000; carry crosses the 17-bit lane boundary.
- Mode 01, len 2; W = 0x1FFFF per term (lane0 all ones), X = 0 -> lane0 wraps to 0x1FFFE, lane1 bits [26:17] = 0; lane0 bit of out_carry set.
- Mode 11, len 0, start -> OUTPUT next cycle, out_data = 0; alu_use_simd = 10; out_ready held low 5 cycles -> out_data stable.
- in_valid toggling 1,0,0,1 with len 2; start pulsed during ACCUM -> exactly 2 terms accumulated, second start ignored, alu_cin = 0 on second term.
- Reset asserted during ACCUM after 1 of 4 terms -> busy, in_ready, out_valid all 0 immediately; a new len-1 transaction returns only that term's sum.
